// File: rtl/seven_seg_if.sv
// Display-side bundle for seven_seg_driver: digit/mask load inputs and the
// registered segment, anode and frame outputs.
interface seven_seg_if;
   logic [15:0] digits_in;
   logic        load;
   logic [3:0]  blink_mask;
   logic [3:0]  dp_mask;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_start;

   modport master (
      output digits_in, load, blink_mask, dp_mask,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  digits_in, load, blink_mask, dp_mask,
      output seg, dp, an, frame_start
   );
endinterface

// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver with blink, decimal points and
// frame-aligned double buffering of the displayed data.
module seven_seg_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_TICKS = 250
) (
   input  logic        clk,
   input  logic        rst,
   seven_seg_if.slave  bus
);
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [15:0]   act_dig_q, act_dig_d;
   logic [3:0]    act_blink_q, act_blink_d;
   logic [3:0]    act_dp_q, act_dp_d;
   logic [15:0]   pend_dig_q, pend_dig_d;
   logic [3:0]    pend_blink_q, pend_blink_d;
   logic [3:0]    pend_dp_q, pend_dp_d;
   logic          pend_valid_q, pend_valid_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    an_q, an_d;
   logic          fs_q, fs_d;

   logic          tick;
   logic [3:0]    cur_code;
   logic [6:0]    cur_seg;

   assign tick     = (presc_q == PRESC_LAST);
   assign cur_code = act_dig_q[{idx_q, 2'b00} +: 4];

   // Active-low {g,f,e,d,c,b,a}
   always_comb begin
      cur_seg = 7'b1111111;
      case (cur_code)
         4'h0: cur_seg = 7'b1000000;
         4'h1: cur_seg = 7'b1111001;
         4'h2: cur_seg = 7'b0100100;
         4'h3: cur_seg = 7'b0110000;
         4'h4: cur_seg = 7'b0011001;
         4'h5: cur_seg = 7'b0010010;
         4'h6: cur_seg = 7'b0000010;
         4'h7: cur_seg = 7'b1111000;
         4'h8: cur_seg = 7'b0000000;
         4'h9: cur_seg = 7'b0010000;
         4'hA: cur_seg = 7'b0001000;
         4'hB: cur_seg = 7'b0000011;
         4'hC: cur_seg = 7'b1000110;
         4'hD: cur_seg = 7'b0100001;
         4'hE: cur_seg = 7'b0000110;
         4'hF: cur_seg = 7'b0001110;
         default: cur_seg = 7'b1111111;
      endcase
   end

   always_comb begin
      presc_d       = tick ? '0 : presc_q + 1'b1;
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      act_dig_d     = act_dig_q;
      act_blink_d   = act_blink_q;
      act_dp_d      = act_dp_q;
      pend_dig_d    = pend_dig_q;
      pend_blink_d  = pend_blink_q;
      pend_dp_d     = pend_dp_q;
      pend_valid_d  = pend_valid_q;
      seg_d         = seg_q;
      dp_d          = dp_q;
      an_d          = an_q;
      fs_d          = 1'b0;

      if (tick) begin
         seg_d = cur_seg;
         dp_d  = ~act_dp_q[idx_q];
         an_d  = (blink_phase_q && act_blink_q[idx_q]) ? 4'b1111 : ~(4'b0001 << idx_q);
         fs_d  = (idx_q == 2'd0);
         idx_d = idx_q + 2'd1;

         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end

         // Swap only after the last digit so a frame never mixes old and new data
         if (idx_q == 2'd3 && pend_valid_q) begin
            act_dig_d    = pend_dig_q;
            act_blink_d  = pend_blink_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
         end
      end

      // A load on the commit tick lands in pending after the swap and stays valid
      if (bus.load) begin
         pend_dig_d   = bus.digits_in;
         pend_blink_d = bus.blink_mask;
         pend_dp_d    = bus.dp_mask;
         pend_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q       <= '0;
         idx_q         <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         act_dig_q     <= 16'h0000;
         act_blink_q   <= 4'h0;
         act_dp_q      <= 4'h0;
         pend_dig_q    <= 16'h0000;
         pend_blink_q  <= 4'h0;
         pend_dp_q     <= 4'h0;
         pend_valid_q  <= 1'b0;
         seg_q         <= 7'b1111111;
         dp_q          <= 1'b1;
         an_q          <= 4'b1111;
         fs_q          <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         act_dig_q     <= act_dig_d;
         act_blink_q   <= act_blink_d;
         act_dp_q      <= act_dp_d;
         pend_dig_q    <= pend_dig_d;
         pend_blink_q  <= pend_blink_d;
         pend_dp_q     <= pend_dp_d;
         pend_valid_q  <= pend_valid_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         fs_q          <= fs_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.frame_start = fs_q;

endmodule
